// File: rtl/draw_pkg.sv
// Shared SEL codes, REQ bit indices and arbiter state encoding for the draw path.
// Also used by the Mux_X/Mux_Y select logic, so the code values must not change.
package draw_pkg;

   localparam logic [2:0] REQ_CF = 3'd0;
   localparam logic [2:0] REQ_CD = 3'd1;
   localparam logic [2:0] REQ_RF = 3'd2;
   localparam logic [2:0] REQ_RD = 3'd3;
   localparam logic [2:0] REQ_LD = 3'd4;
   localparam logic [2:0] REQ_FU = 3'd5;

   localparam logic [3:0] SEL_CF   = 4'd0;
   localparam logic [3:0] SEL_CD   = 4'd1;
   localparam logic [3:0] SEL_RF   = 4'd2;
   localparam logic [3:0] SEL_RD   = 4'd3;
   localparam logic [3:0] SEL_LD   = 4'd4;
   localparam logic [3:0] SEL_FU   = 4'd10;
   localparam logic [3:0] SEL_IDLE = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_ACTIVE  = 2'd2,
      ST_RELEASE = 2'd3
   } arb_state_e;

   function automatic logic [3:0] sel_code(input logic [2:0] idx);
      case (idx)
         REQ_CF:  sel_code = SEL_CF;
         REQ_CD:  sel_code = SEL_CD;
         REQ_RF:  sel_code = SEL_RF;
         REQ_RD:  sel_code = SEL_RD;
         REQ_LD:  sel_code = SEL_LD;
         REQ_FU:  sel_code = SEL_FU;
         default: sel_code = SEL_IDLE;
      endcase
   endfunction

   function automatic logic [2:0] oh5_to_idx(input logic [4:0] oh);
      oh5_to_idx = 3'd0;
      for (int i = 0; i < 5; i++) begin
         if (oh[i]) oh5_to_idx = 3'(i);
      end
   endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational 5-way round-robin picker: first set request at or after ptr_i,
// wrapping 4 -> 0. Zero latency; vld_o low when nothing is requested.
module rr_pick5 (
   input  logic [4:0] req_i,
   input  logic [2:0] ptr_i,
   output logic [4:0] pick_o,
   output logic       vld_o
);

   logic [2:0] idx;

   always_comb begin
      pick_o = '0;
      vld_o  = 1'b0;
      idx    = '0;
      for (int i = 0; i < 5; i++) begin
         idx = 3'((32'(ptr_i) + 32'(i)) % 32'd5);
         if (!vld_o && req_i[idx]) begin
            pick_o[idx] = 1'b1;
            vld_o       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/draw_arbiter.sv
// Pixel X/Y bus arbiter: FU absolute priority, CF..LD round-robin; SEL one cycle ahead of GNT,
// 3 idle cycles between owners. DRAW_ARB_TIMEOUT_EN adds a per-grant timeout with ABORT pulse.
module draw_arbiter
   import draw_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int TO_W           = 13
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [5:0] REQ,
   input  logic [5:0] DONE,
   output logic [5:0] GNT,
   output logic [3:0] SEL,
   output logic       BUSY,
   output logic       ABORT
);

   arb_state_e state_q, state_d;
   logic [2:0] win_q, win_d;
   logic [2:0] ptr_q, ptr_d;
   logic [3:0] sel_q, sel_d;
   logic       abort_q, abort_d;

   logic [4:0] rr_pick;
   logic       rr_vld;
   logic       done_hit;
   logic       req_drop;
   logic       timeout_hit;

   rr_pick5 u_rr_pick5 (
      .req_i  (REQ[4:0]),
      .ptr_i  (ptr_q),
      .pick_o (rr_pick),
      .vld_o  (rr_vld)
   );

   assign done_hit = DONE[win_q];
   assign req_drop = !REQ[win_q];

`ifdef DRAW_ARB_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt_q;

   // Held at zero outside ACTIVE, so it is already clear on the first ACTIVE cycle.
   always_ff @(posedge CLK) begin
      if (RST || state_q != ST_ACTIVE) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_q + 1'b1;
      end
   end

   assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0) ^ (TO_W > 0);
   assign timeout_hit        = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      abort_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (REQ[REQ_FU]) begin
               win_d   = REQ_FU;
               sel_d   = SEL_FU;
               state_d = ST_SETTLE;
            end else if (rr_vld) begin
               win_d   = oh5_to_idx(rr_pick);
               sel_d   = sel_code(oh5_to_idx(rr_pick));
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (done_hit || req_drop || timeout_hit) begin
               state_d = ST_RELEASE;
               sel_d   = SEL_IDLE;
               // A completion or request drop on the timeout cycle wins over the abort.
               abort_d = timeout_hit && !done_hit && !req_drop;
               if (win_q != REQ_FU) begin
                  ptr_d = (win_q == REQ_LD) ? REQ_CF : win_q + 3'd1;
               end
            end
         end
         ST_RELEASE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            sel_d   = SEL_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         win_q   <= REQ_CF;
         ptr_q   <= REQ_CF;
         sel_q   <= SEL_IDLE;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         abort_q <= abort_d;
      end
   end

   always_comb begin
      GNT = '0;
      if (state_q == ST_ACTIVE) GNT[win_q] = 1'b1;
   end

   assign SEL   = sel_q;
   assign BUSY  = (state_q != ST_IDLE);
   assign ABORT = abort_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// Bench for draw_arbiter: directed vector table, multi-cycle sequences, randomized run vs model.
module tb_draw_arbiter;

   localparam int T = 8;
`ifdef DRAW_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST;
   logic [5:0] REQ;
   logic [5:0] DONE;
   logic [5:0] GNT;
   logic [3:0] SEL;
   logic       BUSY;
   logic       ABORT;

   int checks = 0;
   int errors = 0;

   draw_arbiter #(.TIMEOUT_CYCLES(T), .TO_W(4)) dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .DONE(DONE),
      .GNT(GNT), .SEL(SEL), .BUSY(BUSY), .ABORT(ABORT)
   );

   always #5 CLK = ~CLK;

   // Transaction-level reference: owner, whether the grant is live, cooldown, pointer.
   int m_own = -1;
   bit m_granted = 1'b0;
   int m_cool = 0;
   int m_ptr = 0;
   int m_act = 0;
   bit m_abort = 1'b0;

   task automatic model_step(input logic r, input logic [5:0] q, input logic [5:0] d);
      bit fin_done, fin_drop, fin_to;
      if (r) begin
         m_own = -1; m_granted = 1'b0; m_cool = 0; m_ptr = 0; m_abort = 1'b0;
         return;
      end
      m_abort = 1'b0;
      if (m_own < 0) begin
         if (m_cool > 0) m_cool--;
         else if (q[5]) m_own = 5;
         else begin
            for (int i = 0; i < 5; i++) begin
               if (m_own < 0 && q[(m_ptr + i) % 5]) m_own = (m_ptr + i) % 5;
            end
         end
      end else if (!m_granted) begin
         m_granted = 1'b1;
         m_act = 0;
      end else begin
         m_act++;
         fin_done = d[m_own];
         fin_drop = !q[m_own];
         fin_to = TO_EN && (m_act >= T);
         if (fin_done || fin_drop || fin_to) begin
            m_abort = fin_to && !fin_done && !fin_drop;
            if (m_own < 5) m_ptr = (m_own + 1) % 5;
            m_own = -1; m_granted = 1'b0; m_cool = 1;
         end
      end
   endtask

   function automatic int exp_gnt();
      return m_granted ? (1 << m_own) : 0;
   endfunction

   function automatic int exp_sel();
      if (m_own < 0) return 15;
      return (m_own == 5) ? 10 : m_own;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick(input logic r, input logic [5:0] q, input logic [5:0] d);
      RST = r; REQ = q; DONE = d;
      @(posedge CLK);
      model_step(r, q, d);
      #1;
   endtask

   typedef struct {
      logic       rst;
      logic [5:0] req;
      logic [5:0] done;
      logic [5:0] gnt;
      logic [3:0] sel;
      logic       busy;
      logic       abort;
   } vec_t;

   vec_t vecs[21];
   int n, act_cnt, aborts, gap;
   logic [5:0] r_req, r_done;
   logic       r_rst;

   initial begin
      RST = 1'b1; REQ = '0; DONE = '0;

      vecs = '{
         '{1'b1, 6'h3F, 6'h00, 6'h00, 4'hF, 1'b0, 1'b0},  // reset with all REQ high
         '{1'b1, 6'h3F, 6'h00, 6'h00, 4'hF, 1'b0, 1'b0},
         '{1'b0, 6'h3F, 6'h00, 6'h00, 4'hA, 1'b1, 1'b0},  // FU wins, SEL first
         '{1'b0, 6'h3F, 6'h00, 6'h20, 4'hA, 1'b1, 1'b0},
         '{1'b0, 6'h1F, 6'h00, 6'h00, 4'hF, 1'b1, 1'b0},  // FU REQ drop ends grant
         '{1'b0, 6'h05, 6'h00, 6'h00, 4'hF, 1'b0, 1'b0},
         '{1'b0, 6'h05, 6'h00, 6'h00, 4'h0, 1'b1, 1'b0},  // CF from pointer 0
         '{1'b0, 6'h05, 6'h00, 6'h01, 4'h0, 1'b1, 1'b0},
         '{1'b0, 6'h05, 6'h04, 6'h01, 4'h0, 1'b1, 1'b0},  // foreign DONE ignored
         '{1'b0, 6'h05, 6'h01, 6'h00, 4'hF, 1'b1, 1'b0},
         '{1'b0, 6'h04, 6'h00, 6'h00, 4'hF, 1'b0, 1'b0},
         '{1'b0, 6'h04, 6'h00, 6'h00, 4'h2, 1'b1, 1'b0},  // RF next
         '{1'b0, 6'h04, 6'h00, 6'h04, 4'h2, 1'b1, 1'b0},
         '{1'b0, 6'h04, 6'h04, 6'h00, 4'hF, 1'b1, 1'b0},
         '{1'b0, 6'h00, 6'h00, 6'h00, 4'hF, 1'b0, 1'b0},
         '{1'b0, 6'h00, 6'h00, 6'h00, 4'hF, 1'b0, 1'b0},
         '{1'b0, 6'h02, 6'h00, 6'h00, 4'h1, 1'b1, 1'b0},  // CD
         '{1'b0, 6'h02, 6'h00, 6'h02, 4'h1, 1'b1, 1'b0},
         '{1'b1, 6'h02, 6'h00, 6'h00, 4'hF, 1'b0, 1'b0},  // reset mid-ACTIVE
         '{1'b0, 6'h0A, 6'h00, 6'h00, 4'h1, 1'b1, 1'b0},  // pointer back at CF: CD beats RD
         '{1'b0, 6'h0A, 6'h00, 6'h02, 4'h1, 1'b1, 1'b0}
      };

      for (int i = 0; i < 21; i++) begin
         tick(vecs[i].rst, vecs[i].req, vecs[i].done);
         check($sformatf("vec%0d_gnt", i), int'(GNT), int'(vecs[i].gnt));
         check($sformatf("vec%0d_sel", i), int'(SEL), int'(vecs[i].sel));
         check($sformatf("vec%0d_busy", i), int'(BUSY), int'(vecs[i].busy));
         check($sformatf("vec%0d_abort", i), int'(ABORT), int'(vecs[i].abort));
      end

      // All of CF..LD held: strict rotation with a 3-cycle GNT=0 gap.
      tick(1'b1, 6'h00, 6'h00);
      for (int k = 0; k < 6; k++) begin
         n = 0;
         while (GNT == 6'h00 && n < 20) begin
            tick(1'b0, 6'h1F, 6'h00);
            if (GNT == 6'h00) gap++;
            n++;
         end
         check($sformatf("rot%0d_gnt", k), int'(GNT), 1 << (k % 5));
         if (k > 0) check($sformatf("rot%0d_gap", k), gap, 3);
         tick(1'b0, 6'h1F, 6'h00);
         tick(1'b0, 6'h1F, 6'(1 << (k % 5)));
         gap = 1;
      end

      // FU raised while LD owns the bus: LD keeps it, FU next, then CF.
      tick(1'b1, 6'h00, 6'h00);
      n = 0;
      while (GNT == 6'h00 && n < 10) begin tick(1'b0, 6'h10, 6'h00); n++; end
      check("fu_ld_gnt", int'(GNT), 'h10);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 6'h31, 6'h00);
         check($sformatf("fu_ld_hold%0d", i), int'(GNT), 'h10);
      end
      tick(1'b0, 6'h31, 6'h10);
      n = 0;
      while (GNT == 6'h00 && n < 10) begin tick(1'b0, 6'h21, 6'h00); n++; end
      check("fu_gnt", int'(GNT), 'h20);
      check("fu_sel", int'(SEL), 10);
      tick(1'b0, 6'h21, 6'h20);
      n = 0;
      while (GNT == 6'h00 && n < 10) begin tick(1'b0, 6'h03, 6'h00); n++; end
      check("fu_then_cf_gnt", int'(GNT), 'h01);
      check("fu_then_cf_sel", int'(SEL), 0);

      // RD never completes.
      tick(1'b1, 6'h00, 6'h00);
      n = 0;
      while (GNT == 6'h00 && n < 10) begin tick(1'b0, 6'h18, 6'h00); n++; end
      check("to_rd_gnt", int'(GNT), 'h08);
      aborts = 0;
`ifdef DRAW_ARB_TIMEOUT_EN
      act_cnt = 1;
      while (GNT != 6'h00 && act_cnt < 40) begin
         tick(1'b0, 6'h18, 6'h00);
         if (GNT != 6'h00) act_cnt++;
         if (ABORT) aborts++;
      end
      check("to_abort_at_release", int'(ABORT), 1);
      check("to_active_cycles", act_cnt, T);
      n = 0;
      while (GNT == 6'h00 && n < 10) begin
         tick(1'b0, 6'h18, 6'h00);
         if (ABORT) aborts++;
         n++;
      end
      check("to_abort_count", aborts, 1);
      check("to_next_ld", int'(GNT), 'h10);
`else
      for (int i = 0; i < 20; i++) begin
         tick(1'b0, 6'h18, 6'h00);
         if (ABORT) aborts++;
      end
      check("noto_gnt_held", int'(GNT), 'h08);
      check("noto_abort_count", aborts, 0);
`endif

      // Randomized traffic against the model.
      tick(1'b1, 6'h00, 6'h00);
      r_req = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 6; b++) begin
            if (r_req[b]) begin
               if ($urandom_range(0, 11) == 0) r_req[b] = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
               r_req[b] = 1'b1;
            end
         end
         r_done = '0;
         if ($urandom_range(0, 3) == 0) r_done = 6'(1 << $urandom_range(0, 5));
         r_rst = ($urandom_range(0, 399) == 0);
         tick(r_rst, r_req, r_done);
         r_req = r_req & ~r_done;
         check("rnd_gnt", int'(GNT), exp_gnt());
         check("rnd_sel", int'(SEL), exp_sel());
         check("rnd_busy", int'(BUSY), int'((m_own >= 0) || (m_cool > 0)));
         check("rnd_abort", int'(ABORT), int'(m_abort));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
